// File: rtl/dual_moving_avg_pkg.sv
// Shared types for the ECG front end: sample width and the signed sample type
// used on every stage boundary.
package ecg_pkg;

    localparam int DATA_WIDTH = 11;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/dual_moving_avg_if.sv
// Sample-in / averages-out bundle between the ECG source, the dual moving
// average stage and the downstream abs-diff detector.
interface dual_moving_avg_if;

    logic             i_ce;
    ecg_pkg::sample_t i_ecg_sample;
    ecg_pkg::sample_t o_ecg_sample;
    ecg_pkg::sample_t o_ma_short;
    ecg_pkg::sample_t o_ma_long;
    logic             o_ma_short_valid;
    logic             o_ma_long_valid;

    modport master (
        output i_ce,
        output i_ecg_sample,
        input  o_ecg_sample,
        input  o_ma_short,
        input  o_ma_long,
        input  o_ma_short_valid,
        input  o_ma_long_valid
    );

    modport slave (
        input  i_ce,
        input  i_ecg_sample,
        output o_ecg_sample,
        output o_ma_short,
        output o_ma_long,
        output o_ma_short_valid,
        output o_ma_long_valid
    );

endinterface

// File: rtl/dual_moving_avg_ma_window.sv
// One boxcar moving average of 2**LEN_LOG2 samples: circular buffer, running
// sum and a registered floor(sum / LEN) with a sticky "window full" flag.
module ma_window #(
    parameter int DATA_WIDTH = 11,
    parameter int LEN_LOG2   = 3
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_ce,
    input  logic signed [DATA_WIDTH-1:0] i_sample,
    output logic signed [DATA_WIDTH-1:0] o_avg,
    output logic                         o_valid
);

    localparam int                LEN        = 1 << LEN_LOG2;
    localparam int                ACC_W      = DATA_WIDTH + LEN_LOG2;
    localparam logic [LEN_LOG2:0] FULL_COUNT = (LEN_LOG2 + 1)'(LEN);

    logic signed [DATA_WIDTH-1:0] win_buf [LEN];
    logic        [LEN_LOG2-1:0]   ptr;
    logic        [LEN_LOG2:0]     fill;
    logic        [LEN_LOG2:0]     fill_next;
    logic signed [ACC_W-1:0]      sum;
    logic signed [ACC_W-1:0]      sum_next;
    logic signed [DATA_WIDTH-1:0] old_sample;
    logic                         full;

    // Intermediate terms may wrap, but the final sum always fits ACC_W bits,
    // so modular arithmetic at that width gives the exact result.
    always_comb begin
        full       = (fill == FULL_COUNT);
        old_sample = full ? win_buf[ptr] : '0;
        sum_next   = sum
                   + {{LEN_LOG2{i_sample[DATA_WIDTH-1]}}, i_sample}
                   - {{LEN_LOG2{old_sample[DATA_WIDTH-1]}}, old_sample};
        fill_next  = full ? fill : fill + 1'b1;
    end

    // Dropping the low LEN_LOG2 bits is an arithmetic shift: floor toward -inf.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr     <= '0;
            fill    <= '0;
            sum     <= '0;
            o_avg   <= '0;
            o_valid <= 1'b0;
        end else if (i_ce) begin
            ptr     <= ptr + 1'b1;
            fill    <= fill_next;
            sum     <= sum_next;
            o_avg   <= sum_next[ACC_W-1:LEN_LOG2];
            o_valid <= (fill_next == FULL_COUNT);
        end
    end

    // Storage is deliberately left out of reset; the fill count masks stale data.
    always_ff @(posedge i_clk) begin
        if (i_ce) begin
            win_buf[ptr] <= i_sample;
        end
    end

endmodule

// File: rtl/dual_moving_avg.sv
// Fast-trend and baseline moving averages of the ECG stream, presented together
// with the sample that produced them for the abs-diff detector.
module dual_moving_avg
    import ecg_pkg::*;
#(
    parameter int SHORT_LEN_LOG2 = 3,
    parameter int LONG_LEN_LOG2  = 6
) (
    input logic              i_clk,
    input logic              i_rst,
    dual_moving_avg_if.slave bus
);

    ma_window #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_LOG2   (SHORT_LEN_LOG2)
    ) u_short (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_ce     (bus.i_ce),
        .i_sample (bus.i_ecg_sample),
        .o_avg    (bus.o_ma_short),
        .o_valid  (bus.o_ma_short_valid)
    );

    ma_window #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_LOG2   (LONG_LEN_LOG2)
    ) u_long (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_ce     (bus.i_ce),
        .i_sample (bus.i_ecg_sample),
        .o_avg    (bus.o_ma_long),
        .o_valid  (bus.o_ma_long_valid)
    );

    // Sample delay matching the one-cycle latency of the averaging paths.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_ecg_sample <= '0;
        end else if (bus.i_ce) begin
            bus.o_ecg_sample <= bus.i_ecg_sample;
        end
    end

endmodule
